pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
// Saves and restores the 23-bit program counter through the 16-bit data path for CALL/RETURN.
// Push: serialises the PC into two stack words (LSW, then MSW) and writes them to data memory.
// Pop: reads both words back, then replays them on the databus as a pcload + LSW + MSW sequence.
// Sits between the control unit, the data-memory port and the program_counter databus input.
// PARAMETERS
// SP_BASE  16'h0800  stack pointer reset value; lowest legal stack address (even)
// PORTS
// clk_i         in   1   system clock
// rst_ni        in   1   asynchronous active-low reset
// push_i        in   1   start push of pc_addr_i (sampled in StIdle only)
// pop_i         in   1   start pop/restore (sampled in StIdle only)
// pc_addr_i     in   24  current PC byte address; bit0 and bit23 are always 0
// splim_i       in   16  stack limit; highest legal word address (even)
// mem_req_o     out  1   data-memory access request
// mem_we_o      out  1   1=write, 0=read (valid while mem_req_o=1)
// mem_addr_o    out  16  data-memory byte address
// mem_wdata_o   out  16  write data
// mem_rdata_i   in   16  read data, valid with mem_ack_i
// mem_ack_i     in   1   access complete (sampled on clk edge while mem_req_o=1)
// pcload_o      out  1   load strobe to program_counter
// databus_o     out  16  PC word driven toward program_counter
// databus_oe_o  out  1   databus_o is valid/driven
// sp_o          out  16  current stack pointer (next free word)
// busy_o        out  1   1 in any state other than StIdle
// done_o        out  1   one-cycle pulse: push or pop finished
// stk_err_o     out  1   one-cycle pulse: overflow/underflow, operation dropped
// BEHAVIOUR
// Reset: sp_o=SP_BASE; all other outputs 0; state StIdle. Reset mid-operation aborts immediately.
//   No partial SP update survives; mem_req_o drops asynchronously.
// All outputs are registered or decoded from the state register only; no input-to-output comb paths.
// Words: LSW={pc[15:1],1'b0}; MSW={9'b0,pc[22:16]}. Both are captured from pc_addr_i when push is accepted.
// StIdle:
//   push_i has priority over pop_i. If both are high, only the push runs and pop_i is dropped, not queued.
//   push: if sp+4 > splim_i -> stk_err_o pulse next cycle, stay StIdle, no access.
//     Otherwise -> StPushLo.
//   pop: if sp < SP_BASE+4 -> stk_err_o pulse next cycle, no access.
//     Otherwise -> StPopHi.
// StPushLo:  req=1, we=1, addr=sp, wdata=LSW. On ack: sp+=2 -> StPushHi.
// StPushHi:  req=1, we=1, addr=sp, wdata=MSW. On ack: sp+=2, done_o=1 next cycle -> StIdle.
// StPopHi:   req=1, we=0, addr=sp-2. On ack: latch MSW, sp-=2 -> StPopLo.
// StPopLo:   req=1, we=0, addr=sp-2. On ack: latch LSW (bit0 forced 0), sp-=2 -> StPcLoad.
// StPcLoad:  pcload_o=1, databus_oe_o=0 for exactly 1 cycle -> StPcLsw.
// StPcLsw:   databus_o=LSW, oe=1 for 1 cycle -> StPcMsw.
// StPcMsw:   databus_o=MSW, oe=1 for 1 cycle, done_o=1 next cycle -> StIdle.
// Memory handshake:
//   req/we/addr/wdata are held stable until the edge at which ack=1; req drops in the following state.
//   ack with req=0 is ignored. Zero-wait ack (ack high the first req cycle) completes that access in 1 cycle.
// Latency with zero-wait memory:
//   push: req in cycles 1-2 after acceptance, done_o in cycle 3.
//   pop: reads in cycles 1-2, pcload in 3, LSW in 4, MSW in 5, done_o in 6.
// push_i/pop_i while busy_o=1 are ignored. sp arithmetic is 16-bit. Limit checks are unsigned and cannot wrap,
//   because check failure prevents the update. databus_o=0 whenever oe=0.
// TESTING
// T1: reset; push with pc_addr_i=24'h012346, sp=0800, zero-wait ack
//   -> writes [0800]=2346, [0802]=0001; sp=0804; done_o in cycle 3.
// T2: pop after T1 -> reads 0802 then 0800; pcload cycle 3; databus=2346 in cycle 4, 0001 in cycle 5;
//   sp=0800; program_counter ends at 012346.
// T3: push with 3-cycle ack delay on each access -> addr/wdata stable during wait; done_o in cycle 7; sp+=4 once.
// T4: splim_i=0802, sp=0800, push -> stk_err_o pulse, no mem_req_o, sp unchanged.
//   Pop at sp=SP_BASE -> stk_err_o, no access.
// T5: push_i and pop_i high together in StIdle -> push only.
//   push_i pulsed during a pop -> ignored, pop completes correctly.
// T6: rst_ni low while StPushHi is waiting for ack -> mem_req_o=0 immediately; sp=0800, busy_o=0.
//   Next push works normally.

Source files
------------

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_unit
// Brief    : Pushes/pops the 23-bit PC as two 16-bit stack words for CALL/RETURN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
    parameter logic [15:0] SP_BASE = 16'h0800
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [23:0] pc_addr_i,
    input  logic [15:0] splim_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        pcload_o,
    output logic [15:0] databus_o,
    output logic        databus_oe_o,
    output logic [15:0] sp_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        stk_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH_LO = 3'd1,
        ST_PUSH_HI = 3'd2,
        ST_POP_HI  = 3'd3,
        ST_POP_LO  = 3'd4,
        ST_PC_LOAD = 3'd5,
        ST_PC_LSW  = 3'd6,
        ST_PC_MSW  = 3'd7
    } state_t;

    state_t      r_state;
    logic [15:0] r_sp;
    logic [15:0] r_lsw;
    logic [15:0] r_msw;
    logic        r_done;
    logic        r_err;

    logic        w_push_ok;
    logic        w_pop_ok;
    logic [15:0] w_sp_inc;
    logic [15:0] w_sp_dec;

    // Limit checks evaluated in 17 bits so the comparison itself cannot wrap.
    assign w_push_ok = ({1'b0, r_sp} + 17'd4) <= {1'b0, splim_i};
    assign w_pop_ok  = {1'b0, r_sp} >= ({1'b0, SP_BASE} + 17'd4);
    assign w_sp_inc  = r_sp + 16'd2;
    assign w_sp_dec  = r_sp - 16'd2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_sp    <= SP_BASE;
            r_lsw   <= 16'h0000;
            r_msw   <= 16'h0000;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (push_i) begin
                        if (w_push_ok) begin
                            r_lsw   <= {pc_addr_i[15:1], 1'b0};
                            r_msw   <= {9'b0, pc_addr_i[22:16]};
                            r_state <= ST_PUSH_LO;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (pop_i) begin
                        if (w_pop_ok) begin
                            r_state <= ST_POP_HI;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_PUSH_LO: begin
                    if (mem_ack_i) begin
                        r_sp    <= w_sp_inc;
                        r_state <= ST_PUSH_HI;
                    end
                end
                ST_PUSH_HI: begin
                    if (mem_ack_i) begin
                        r_sp    <= w_sp_inc;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_POP_HI: begin
                    if (mem_ack_i) begin
                        r_msw   <= mem_rdata_i;
                        r_sp    <= w_sp_dec;
                        r_state <= ST_POP_LO;
                    end
                end
                ST_POP_LO: begin
                    if (mem_ack_i) begin
                        r_lsw   <= {mem_rdata_i[15:1], 1'b0};
                        r_sp    <= w_sp_dec;
                        r_state <= ST_PC_LOAD;
                    end
                end
                ST_PC_LOAD: r_state <= ST_PC_LSW;
                ST_PC_LSW:  r_state <= ST_PC_MSW;
                ST_PC_MSW: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = 16'h0000;
        mem_wdata_o  = 16'h0000;
        pcload_o     = 1'b0;
        databus_o    = 16'h0000;
        databus_oe_o = 1'b0;
        case (r_state)
            ST_PUSH_LO: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_sp;
                mem_wdata_o = r_lsw;
            end
            ST_PUSH_HI: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_sp;
                mem_wdata_o = r_msw;
            end
            ST_POP_HI, ST_POP_LO: begin
                mem_req_o  = 1'b1;
                mem_addr_o = w_sp_dec;
            end
            ST_PC_LOAD: pcload_o = 1'b1;
            ST_PC_LSW: begin
                databus_o    = r_lsw;
                databus_oe_o = 1'b1;
            end
            ST_PC_MSW: begin
                databus_o    = r_msw;
                databus_oe_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign sp_o      = r_sp;
    assign busy_o    = (r_state != ST_IDLE);
    assign done_o    = r_done;
    assign stk_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_stack_unit
// Brief    : Directed bench for pc_stack_unit with a behavioural data memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        push_i;
    logic        pop_i;
    logic [23:0] pc_addr_i;
    logic [15:0] splim_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i = 16'h0000;
    logic        mem_ack_i = 1'b0;
    logic        pcload_o;
    logic [15:0] databus_o;
    logic        databus_oe_o;
    logic [15:0] sp_o;
    logic        busy_o;
    logic        done_o;
    logic        stk_err_o;

    pc_stack_unit #(.SP_BASE(16'h0800)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (push_i),
        .pop_i        (pop_i),
        .pc_addr_i    (pc_addr_i),
        .splim_i      (splim_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .pcload_o     (pcload_o),
        .databus_o    (databus_o),
        .databus_oe_o (databus_oe_o),
        .sp_o         (sp_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .stk_err_o    (stk_err_o)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] mem [0:4095];
    int ack_delay = 0;
    int wcnt      = 0;
    int n_acc     = 0;
    int tests     = 0;
    int fails     = 0;

    // Memory model: ack after ack_delay wait cycles, write on the acked edge.
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            wcnt = 0;
        end else if (mem_req_o && mem_ack_i) begin
            if (mem_we_o) mem[mem_addr_o[12:1]] = mem_wdata_o;
            n_acc = n_acc + 1;
            wcnt  = 0;
        end else if (mem_req_o) begin
            wcnt = wcnt + 1;
        end
    end

    always @(negedge clk_i) begin
        mem_ack_i   = mem_req_o && (wcnt >= ack_delay);
        mem_rdata_i = mem_ack_i ? mem[mem_addr_o[12:1]] : 16'h0000;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        while (!done_o && k < bound) begin
            step();
            k++;
        end
        chk(tag, {31'b0, done_o}, 32'd1);
    endtask

    logic [15:0] lsw_seen;
    logic [15:0] msw_seen;
    int          n0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        rst_ni = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        pc_addr_i = 24'h0; splim_i = 16'h0FFE;
        step(); step();
        chk("rst_sp",     {16'b0, sp_o}, 32'h0800);
        chk("rst_busy",   {31'b0, busy_o}, 0);
        chk("rst_req",    {31'b0, mem_req_o}, 0);
        chk("rst_done",   {31'b0, done_o}, 0);
        chk("rst_err",    {31'b0, stk_err_o}, 0);
        chk("rst_oe",     {31'b0, databus_oe_o}, 0);
        chk("rst_bus",    {16'b0, databus_o}, 0);
        rst_ni = 1'b1;
        step();

        // T1: zero-wait push
        pc_addr_i = 24'h012346; push_i = 1'b1; step(); push_i = 1'b0;
        chk("t1_c1_req",   {31'b0, mem_req_o}, 1);
        chk("t1_c1_we",    {31'b0, mem_we_o}, 1);
        chk("t1_c1_addr",  {16'b0, mem_addr_o}, 32'h0800);
        chk("t1_c1_wdata", {16'b0, mem_wdata_o}, 32'h2346);
        step();
        chk("t1_c2_addr",  {16'b0, mem_addr_o}, 32'h0802);
        chk("t1_c2_wdata", {16'b0, mem_wdata_o}, 32'h0001);
        step();
        chk("t1_c3_done",  {31'b0, done_o}, 1);
        chk("t1_c3_req",   {31'b0, mem_req_o}, 0);
        chk("t1_c3_busy",  {31'b0, busy_o}, 0);
        chk("t1_sp",       {16'b0, sp_o}, 32'h0804);
        chk("t1_mem0800",  {16'b0, mem[12'h400]}, 32'h2346);
        chk("t1_mem0802",  {16'b0, mem[12'h401]}, 32'h0001);
        step();
        chk("t1_done_pulse", {31'b0, done_o}, 0);

        // T2: zero-wait pop and PC replay
        pop_i = 1'b1; step(); pop_i = 1'b0;
        chk("t2_c1_req",  {31'b0, mem_req_o}, 1);
        chk("t2_c1_we",   {31'b0, mem_we_o}, 0);
        chk("t2_c1_addr", {16'b0, mem_addr_o}, 32'h0802);
        step();
        chk("t2_c2_addr", {16'b0, mem_addr_o}, 32'h0800);
        step();
        chk("t2_c3_pcload", {31'b0, pcload_o}, 1);
        chk("t2_c3_oe",     {31'b0, databus_oe_o}, 0);
        chk("t2_c3_req",    {31'b0, mem_req_o}, 0);
        step();
        chk("t2_c4_bus",    {16'b0, databus_o}, 32'h2346);
        chk("t2_c4_oe",     {31'b0, databus_oe_o}, 1);
        chk("t2_c4_pcload", {31'b0, pcload_o}, 0);
        lsw_seen = databus_o;
        step();
        chk("t2_c5_bus",    {16'b0, databus_o}, 32'h0001);
        chk("t2_c5_oe",     {31'b0, databus_oe_o}, 1);
        msw_seen = databus_o;
        step();
        chk("t2_c6_done",   {31'b0, done_o}, 1);
        chk("t2_sp",        {16'b0, sp_o}, 32'h0800);
        chk("t2_pc",        {8'b0, 1'b0, msw_seen[6:0], lsw_seen}, 32'h012346);

        // T3: 3-cycle accesses, signals held stable while waiting
        ack_delay = 2; n0 = n_acc;
        pc_addr_i = 24'h7FFFFE; push_i = 1'b1; step(); push_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("t3_c%0d_req", c),   {31'b0, mem_req_o}, 1);
            chk($sformatf("t3_c%0d_addr", c),  {16'b0, mem_addr_o}, (c <= 3) ? 32'h0800 : 32'h0802);
            chk($sformatf("t3_c%0d_wdata", c), {16'b0, mem_wdata_o}, (c <= 3) ? 32'hFFFE : 32'h007F);
            chk($sformatf("t3_c%0d_done", c),  {31'b0, done_o}, 0);
            step();
        end
        chk("t3_c7_done", {31'b0, done_o}, 1);
        chk("t3_sp",      {16'b0, sp_o}, 32'h0804);
        chk("t3_nacc",    n_acc, n0 + 2);
        ack_delay = 0;
        step();
        pop_i = 1'b1; step(); pop_i = 1'b0;
        wait_done("t3_pop_done", 20);
        chk("t3_pop_sp", {16'b0, sp_o}, 32'h0800);
        step();

        // T4: overflow and underflow
        splim_i = 16'h0802; n0 = n_acc;
        pc_addr_i = 24'h001000; push_i = 1'b1; step(); push_i = 1'b0;
        chk("t4_ovf_err",  {31'b0, stk_err_o}, 1);
        chk("t4_ovf_req",  {31'b0, mem_req_o}, 0);
        chk("t4_ovf_busy", {31'b0, busy_o}, 0);
        step();
        chk("t4_ovf_pulse", {31'b0, stk_err_o}, 0);
        chk("t4_ovf_sp",    {16'b0, sp_o}, 32'h0800);
        pop_i = 1'b1; step(); pop_i = 1'b0;
        chk("t4_unf_err", {31'b0, stk_err_o}, 1);
        chk("t4_unf_req", {31'b0, mem_req_o}, 0);
        step();
        chk("t4_unf_sp",   {16'b0, sp_o}, 32'h0800);
        chk("t4_nacc",     n_acc, n0);
        splim_i = 16'h0804;
        pc_addr_i = 24'h000010; push_i = 1'b1; step(); push_i = 1'b0;
        chk("t4_edge_err", {31'b0, stk_err_o}, 0);
        chk("t4_edge_req", {31'b0, mem_req_o}, 1);
        wait_done("t4_edge_done", 20);
        chk("t4_edge_sp", {16'b0, sp_o}, 32'h0804);
        step();
        pop_i = 1'b1; step(); pop_i = 1'b0;
        wait_done("t4_edge_pop_done", 20);
        chk("t4_edge_pop_sp", {16'b0, sp_o}, 32'h0800);
        splim_i = 16'h0FFE;
        step();

        // T5: push wins over pop; push during pop ignored
        pc_addr_i = 24'h000ABC; push_i = 1'b1; pop_i = 1'b1; step();
        push_i = 1'b0; pop_i = 1'b0;
        chk("t5_both_req", {31'b0, mem_req_o}, 1);
        chk("t5_both_we",  {31'b0, mem_we_o}, 1);
        wait_done("t5_push_done", 20);
        chk("t5_push_sp", {16'b0, sp_o}, 32'h0804);
        step();
        chk("t5_no_pop_busy", {31'b0, busy_o}, 0);
        n0 = n_acc;
        pop_i = 1'b1; step(); pop_i = 1'b0;
        push_i = 1'b1; step(); push_i = 1'b0;
        step();
        chk("t5_pcload", {31'b0, pcload_o}, 1);
        step();
        chk("t5_lsw", {16'b0, databus_o}, 32'h0ABC);
        step();
        chk("t5_msw", {16'b0, databus_o}, 32'h0000);
        chk("t5_msw_oe", {31'b0, databus_oe_o}, 1);
        step();
        chk("t5_pop_done", {31'b0, done_o}, 1);
        chk("t5_pop_sp",   {16'b0, sp_o}, 32'h0800);
        chk("t5_nacc",     n_acc, n0 + 2);
        step();
        chk("t5_idle", {31'b0, busy_o}, 0);

        // T6: async reset while the high word write is waiting
        ack_delay = 3;
        pc_addr_i = 24'h2A5554; push_i = 1'b1; step(); push_i = 1'b0;
        repeat (4) step();
        chk("t6_hi_addr", {16'b0, mem_addr_o}, 32'h0802);
        chk("t6_hi_req",  {31'b0, mem_req_o}, 1);
        chk("t6_hi_sp",   {16'b0, sp_o}, 32'h0802);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_req",  {31'b0, mem_req_o}, 0);
        chk("t6_rst_sp",   {16'b0, sp_o}, 32'h0800);
        chk("t6_rst_busy", {31'b0, busy_o}, 0);
        step(); step();
        rst_ni = 1'b1; ack_delay = 0;
        step();
        push_i = 1'b1; step(); push_i = 1'b0;
        chk("t6_c1_addr",  {16'b0, mem_addr_o}, 32'h0800);
        chk("t6_c1_wdata", {16'b0, mem_wdata_o}, 32'h5554);
        step();
        chk("t6_c2_wdata", {16'b0, mem_wdata_o}, 32'h002A);
        step();
        chk("t6_c3_done", {31'b0, done_o}, 1);
        chk("t6_sp",      {16'b0, sp_o}, 32'h0804);
        chk("t6_mem0800", {16'b0, mem[12'h400]}, 32'h5554);
        chk("t6_mem0802", {16'b0, mem[12'h401]}, 32'h002A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
